window_extract: RTL
===================

WINDOW_EXTRACT -- requirements
Module: window_extract

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- P_W, 12, position counter width.
- C_W, 8, colour channel width.
- IMG_X, 640, input frame width in pixels.
- IMG_Y, 480, input frame height in lines.
- WX1, 160, first in-window column, inclusive.
- WX2, 479, last in-window column, inclusive.
- WY1, 120, first in-window line, inclusive.
- WY2, 359, last in-window line, inclusive.
REQ-002 Ports, one per line: name, direction, width, meaning.
- sys_clk, in, 1, single clock.
- sys_rst_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, input pixel strobe.
- i_sof, in, 1, start of frame; qualified by i_valid; marks pixel (0,0).
- i_R / i_G / i_B, in, C_W each, input colour channels.
- o_valid, out, 1, output pixel strobe.
- o_sof, out, 1, first window pixel of frame.
- o_eol, out, 1, last window pixel of a window line.
- o_eof, out, 1, last window pixel of frame.
- o_x / o_y, out, P_W each, window-relative coordinates.
- o_R / o_G / o_B, out, C_W each, output colour channels.
- o_frame_err, out, 1, one-cycle error pulse.
REQ-003 The block SHALL have one clock, sys_clk; reset sys_rst_n is asynchronous and active-low.

Function
REQ-004 The block SHALL be the consumer of a full-frame masked pixel stream: it forwards only in-window pixels, compacted, with framing flags. The stream has no backpressure.
REQ-005 FSM states SHALL be S_SYNC and S_RUN.
- Reset state is S_SYNC.
- S_SYNC -> S_RUN on i_valid && i_sof.
- In S_SYNC, pixels without i_sof are discarded and produce no output.
REQ-006 Input counters cnt_x / cnt_y (P_W bits) SHALL track input position.
- On the accepting i_sof pixel: the pixel is treated as (0,0); counters then advance to (1,0).
- In S_RUN, each i_valid advances cnt_x. At IMG_X-1, cnt_x wraps to 0 and cnt_y increments.
- At (IMG_X-1, IMG_Y-1), both counters wrap to 0.
- No change when i_valid=0.
REQ-007 A pixel is in-window iff WX1<=x<=WX2 and WY1<=y<=WY2, evaluated on the pixel's own position (the pre-increment counter value, or (0,0) for the i_sof pixel).
REQ-008 Latency SHALL be exactly 1 cycle. An in-window input at cycle n gives o_valid=1 at n+1 with o_R/o_G/o_B equal to that input's channels.
REQ-009 In all other cycles o_valid SHALL be 0.
- o_R/o_G/o_B, o_x, o_y hold their last values.
- o_sof, o_eol, o_eof are 0.
REQ-010 Output coordinates: o_x = x-WX1 and o_y = y-WY1, computed at P_W bits with no overflow.
REQ-011 Framing flags are asserted only with o_valid.
- o_sof=1 iff (x,y)=(WX1,WY1).
- o_eol=1 iff x=WX2.
- o_eof=1 iff (x,y)=(WX2,WY2).
- o_eof always coincides with o_eol.
REQ-012 i_valid && i_sof while in S_RUN with counters not at (0,0):
- pulse o_frame_err for 1 cycle;
- force the pixel to (0,0), re-apply REQ-007 to it, and continue in S_RUN.
- An i_sof arriving exactly at counter (0,0) is normal and raises no error.
REQ-013 i_sof without i_valid SHALL be ignored.
REQ-014 A frame ending early (short frame) followed by i_sof SHALL be handled by REQ-012; no output is synthesised for missing pixels.
REQ-015 Window parameters SHALL satisfy WX1<=WX2<IMG_X and WY1<=WY2<IMG_Y; WX1=WX2 and WY1=WY2 (a 1x1 window) are legal, in which case o_sof, o_eol and o_eof are all asserted on the single output pixel.

Reset
REQ-016 On sys_rst_n=0 the block SHALL immediately, asynchronously:
- clear all outputs to 0;
- clear cnt_x and cnt_y to 0;
- enter S_SYNC.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame. Output resumes only after the next i_valid && i_sof following reset release.

Verification (IMG_X=8, IMG_Y=6, WX1=2, WX2=4, WY1=1, WY2=3, P_W=4, C_W=8)
REQ-018 Stream 20 pixels with no i_sof after reset -> o_valid stays 0.
REQ-019 One full frame with i_sof on the first pixel and continuous i_valid:
- o_valid pulses 9 times, 1 cycle after input (1*8+2)=10, 11, 12, 18..20, 26..28;
- o_sof on the 1st pulse, o_eol on the 3rd/6th/9th pulses, o_eof on the 9th;
- (o_x,o_y) runs (0,0) to (2,2).
REQ-020 Same frame with i_valid deasserted every other cycle -> identical output sequence, each output 1 cycle after its input pixel.
REQ-021 Second i_sof at input pixel 15 of a frame:
- o_frame_err pulses once;
- that pixel is treated as (0,0) and is out-of-window;
- the next o_sof appears at the 11th pixel counted from that i_sof.
REQ-022 sys_rst_n low for 2 cycles after input pixel 19, then the frame continues without i_sof -> no output until the next i_sof; that frame then matches REQ-019.
REQ-023 Two back-to-back frames -> 18 o_valid pulses, two o_eof, no o_frame_err.

Source files
------------

// File: rtl/window_extract.sv
// Window extractor: forwards only in-window pixels of a full-frame stream,
// re-based to window coordinates, with frame/line markers and one-cycle latency.
module window_extract #(
    parameter int P_W   = 12,
    parameter int C_W   = 8,
    parameter int IMG_X = 640,
    parameter int IMG_Y = 480,
    parameter int WX1   = 160,
    parameter int WX2   = 479,
    parameter int WY1   = 120,
    parameter int WY2   = 359
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           i_valid,
    input  logic           i_sof,
    input  logic [C_W-1:0] i_R,
    input  logic [C_W-1:0] i_G,
    input  logic [C_W-1:0] i_B,
    output logic           o_valid,
    output logic           o_sof,
    output logic           o_eol,
    output logic           o_eof,
    output logic [P_W-1:0] o_x,
    output logic [P_W-1:0] o_y,
    output logic [C_W-1:0] o_R,
    output logic [C_W-1:0] o_G,
    output logic [C_W-1:0] o_B,
    output logic           o_frame_err
);

    typedef enum logic {S_SYNC, S_RUN} state_t;

    localparam logic [P_W-1:0] X_LAST = P_W'(IMG_X - 1);
    localparam logic [P_W-1:0] Y_LAST = P_W'(IMG_Y - 1);
    localparam logic [P_W-1:0] X_LO   = P_W'(WX1);
    localparam logic [P_W-1:0] X_HI   = P_W'(WX2);
    localparam logic [P_W-1:0] Y_LO   = P_W'(WY1);
    localparam logic [P_W-1:0] Y_HI   = P_W'(WY2);

    state_t         state_q, state_d;
    logic [P_W-1:0] cnt_x_q, cnt_x_d;
    logic [P_W-1:0] cnt_y_q, cnt_y_d;

    logic           valid_q, valid_d;
    logic           sof_q, sof_d;
    logic           eol_q, eol_d;
    logic           eof_q, eof_d;
    logic [P_W-1:0] x_q, x_d;
    logic [P_W-1:0] y_q, y_d;
    logic [C_W-1:0] r_q, r_d;
    logic [C_W-1:0] g_q, g_d;
    logic [C_W-1:0] b_q, b_d;
    logic           err_q, err_d;

    logic           restart;
    logic           accept;
    logic [P_W-1:0] pix_x;
    logic [P_W-1:0] pix_y;
    logic           in_win;

    // A qualified start-of-frame always pins the current pixel to (0,0).
    always_comb begin
        restart = i_valid && i_sof;
        accept  = i_valid && (i_sof || (state_q == S_RUN));
        pix_x   = restart ? '0 : cnt_x_q;
        pix_y   = restart ? '0 : cnt_y_q;
        in_win  = (pix_x >= X_LO) && (pix_x <= X_HI) &&
                  (pix_y >= Y_LO) && (pix_y <= Y_HI);
    end

    always_comb begin
        state_d = state_q;
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        if (accept) begin
            state_d = S_RUN;
            if (pix_x == X_LAST) begin
                cnt_x_d = '0;
                cnt_y_d = (pix_y == Y_LAST) ? '0 : pix_y + 1'b1;
            end else begin
                cnt_x_d = pix_x + 1'b1;
                cnt_y_d = pix_y;
            end
        end
    end

    // Payload registers hold their last value between output strobes.
    always_comb begin
        valid_d = accept && in_win;
        sof_d   = valid_d && (pix_x == X_LO) && (pix_y == Y_LO);
        eol_d   = valid_d && (pix_x == X_HI);
        eof_d   = valid_d && (pix_x == X_HI) && (pix_y == Y_HI);
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        if (valid_d) begin
            x_d = pix_x - X_LO;
            y_d = pix_y - Y_LO;
            r_d = i_R;
            g_d = i_G;
            b_d = i_B;
        end
        err_d = restart && (state_q == S_RUN) &&
                ((cnt_x_q != '0) || (cnt_y_q != '0));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_SYNC;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_sof       = sof_q;
    assign o_eol       = eol_q;
    assign o_eof       = eof_q;
    assign o_x         = x_q;
    assign o_y         = y_q;
    assign o_R         = r_q;
    assign o_G         = g_q;
    assign o_B         = b_q;
    assign o_frame_err = err_q;

endmodule
